// File: rtl/axis_len_pkg.sv
// rtl/axis_len_pkg.sv - shared widths, flag indices and state type for the packet length tap
package axis_len_pkg;

    localparam int C_S_AXIS_DATA_WIDTH = 256;
    localparam int KEEP_WIDTH          = C_S_AXIS_DATA_WIDTH / 8;
    localparam int CNT_WIDTH           = $clog2(KEEP_WIDTH + 2);

    localparam int FLAG_KEEP_ERR = 0;
    localparam int FLAG_SAT      = 1;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } len_state_t;

endpackage

// File: rtl/len_record_fifo.sv
// rtl/len_record_fifo.sv - first-word-fall-through record FIFO with occupancy counter and drop pulse
module len_record_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_drop,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_accept;

    assign w_pop    = (r_count != '0) && i_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_accept = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);
    assign o_drop   = i_push && !w_accept;
    assign o_valid  = (r_count != '0);
    assign o_data   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/one_hot_to_count.sv
// rtl/one_hot_to_count.sv - one-hot position to 1-based count, zero when not exactly one bit set
module one_hot_to_count
    import axis_len_pkg::*;
#(
    parameter int IN_WIDTH  = KEEP_WIDTH,
    parameter int OUT_WIDTH = CNT_WIDTH
) (
    input  logic [IN_WIDTH-1:0]  i_one_hot,
    output logic [OUT_WIDTH-1:0] o_count
);

    logic w_seen;
    logic w_multi;
    logic [OUT_WIDTH-1:0] w_pos;

    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (i_one_hot[i]) begin
                w_multi = w_multi | w_seen;
                w_seen  = 1'b1;
                w_pos   = OUT_WIDTH'(i + 1);
            end
        end
        o_count = (w_seen && !w_multi) ? w_pos : '0;
    end

endmodule

// File: rtl/axis_packet_length.sv
// rtl/axis_packet_length.sv - passive AXI-Stream tap measuring packet bytes and beats into a record FIFO
module axis_packet_length #(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int LEN_WIDTH           = 16,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                             s_axis_tlast,
    output logic                             m_len_valid,
    input  logic                             m_len_ready,
    output logic [LEN_WIDTH-1:0]             m_len_bytes,
    output logic [LEN_WIDTH-1:0]             m_len_beats,
    output logic [1:0]                       m_len_flags,
    output logic                             in_packet,
    output logic [15:0]                      drop_count
);

    import axis_len_pkg::*;

    localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int CW    = $clog2(KW + 2);
    localparam int REC_W = 2 * LEN_WIDTH + 2;
    localparam logic [LEN_WIDTH:0] LEN_MAX = {1'b0, {LEN_WIDTH{1'b1}}};

    len_state_t r_state;
    len_state_t w_state_nxt;

    logic [LEN_WIDTH-1:0] r_bytes;
    logic [LEN_WIDTH-1:0] r_beats;
    logic [1:0]           r_flags;
    logic [15:0]          r_drop_count;

    logic                 w_beat;
    logic [KW-1:0]        w_last_oh;
    logic [CW-1:0]        w_cnt;
    logic [LEN_WIDTH:0]   w_byte_inc;
    logic [LEN_WIDTH:0]   w_bytes_sum;
    logic [LEN_WIDTH:0]   w_beats_sum;
    logic                 w_sat;
    logic                 w_keep_err;
    logic [LEN_WIDTH-1:0] w_bytes_fin;
    logic [LEN_WIDTH-1:0] w_beats_fin;
    logic [1:0]           w_flags_fin;
    logic                 w_push;
    logic                 w_drop;
    logic [REC_W-1:0]     w_push_data;
    logic [REC_W-1:0]     w_head;

    assign w_beat    = s_axis_tvalid && s_axis_tready;
    // The top bit survives the shift mask unchanged, so a full keep marks byte 31.
    assign w_last_oh = s_axis_tkeep & ~(s_axis_tkeep >> 1);

    one_hot_to_count #(
        .IN_WIDTH  (KW),
        .OUT_WIDTH (CW)
    ) u_one_hot_to_count (
        .i_one_hot (w_last_oh),
        .o_count   (w_cnt)
    );

    always_comb begin
        w_byte_inc  = s_axis_tlast ? (LEN_WIDTH+1)'(w_cnt) : (LEN_WIDTH+1)'(KW);
        w_bytes_sum = {1'b0, r_bytes} + w_byte_inc;
        w_beats_sum = {1'b0, r_beats} + 1'b1;
        w_sat       = (w_bytes_sum > LEN_MAX) || (w_beats_sum > LEN_MAX);
        w_keep_err  = s_axis_tlast && (w_cnt == '0);
        w_bytes_fin = (w_bytes_sum > LEN_MAX) ? LEN_MAX[LEN_WIDTH-1:0] : w_bytes_sum[LEN_WIDTH-1:0];
        w_beats_fin = (w_beats_sum > LEN_MAX) ? LEN_MAX[LEN_WIDTH-1:0] : w_beats_sum[LEN_WIDTH-1:0];
        w_flags_fin = r_flags;
        w_flags_fin[FLAG_SAT]      = r_flags[FLAG_SAT] | w_sat;
        w_flags_fin[FLAG_KEEP_ERR] = r_flags[FLAG_KEEP_ERR] | w_keep_err;
    end

    assign w_push      = w_beat && s_axis_tlast;
    assign w_push_data = {w_flags_fin, w_beats_fin, w_bytes_fin};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_beat && !s_axis_tlast) w_state_nxt = ST_IN_PKT;
            ST_IN_PKT: if (w_beat && s_axis_tlast)  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bytes      <= '0;
            r_beats      <= '0;
            r_flags      <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_beat) begin
                if (s_axis_tlast) begin
                    r_bytes <= '0;
                    r_beats <= '0;
                    r_flags <= '0;
                end else begin
                    r_bytes <= w_bytes_fin;
                    r_beats <= w_beats_fin;
                    r_flags <= w_flags_fin;
                end
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    len_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_len_record_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .o_drop      (w_drop),
        .o_valid     (m_len_valid),
        .i_ready     (m_len_ready),
        .o_data      (w_head)
    );

    assign m_len_bytes = w_head[LEN_WIDTH-1:0];
    assign m_len_beats = w_head[2*LEN_WIDTH-1:LEN_WIDTH];
    assign m_len_flags = w_head[REC_W-1:2*LEN_WIDTH];
    assign in_packet   = (r_state == ST_IN_PKT);
    assign drop_count  = r_drop_count;

endmodule
